// File: rtl/mips_pkg.sv
// Shared writeback types: register address/data widths and the queued-write entry.
package mips_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order holding FIFO for ALU results that lost the write port; every slot is
// exposed together with a per-slot valid bit so the parent can build pendingMask.
module wb_fifo
   import mips_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  wb_entry_t        pushEntry_i,
   input  logic             pop_i,
   output wb_entry_t        head_o,
   output wb_entry_t        entries_o [DEPTH],
   output logic [DEPTH-1:0] validMask_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] wrPtr_q;
   logic [PTR_W-1:0] rdPtr_q;
   logic [CNT_W-1:0] count_q;
   wb_entry_t        mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[wrPtr_q] <= pushEntry_i;
            wrPtr_q        <= wrPtr_q + 1'b1;
         end
         if (pop_i) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
      end
   end

   // A slot is live when its distance from the read pointer is below the fill count.
   always_comb begin
      logic [PTR_W-1:0] offset;
      offset      = '0;
      validMask_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset         = PTR_W'(i) - rdPtr_q;
         validMask_o[i] = CNT_W'(offset) < count_q;
         entries_o[i]   = mem_q[i];
      end
   end

   assign head_o  = mem_q[rdPtr_q];
   assign count_o = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: loads always win the register-file port, ALU results queue behind them.
// Define WB_COUNT_EN to add the writeCount/stallCount statistics outputs.
module wb_arbiter #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int ADDR_W = mips_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              loadValid,
   input  logic [ADDR_W-1:0] loadAddr,
   input  logic [DATA_W-1:0] loadData,
   input  logic              aluValid,
   output logic              aluReady,
   input  logic [ADDR_W-1:0] aluAddr,
   input  logic [DATA_W-1:0] aluData,
   output logic              regWrite,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] data,
`ifdef WB_COUNT_EN
   output logic [31:0]       writeCount,
   output logic [31:0]       stallCount,
`endif
   output logic [31:0]       pendingMask
);

   import mips_pkg::wb_entry_t;

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [CNT_W-1:0] fifoCount;
   wb_entry_t        fifoHead;
   wb_entry_t        fifoEntries [DEPTH];
   logic [DEPTH-1:0] fifoValid;

   logic      aluFire;
   logic      push;
   logic      pop;
   logic      winValid;
   wb_entry_t winner;
   wb_entry_t aluEntry;

   logic              regWrite_q, regWrite_d;
   logic [ADDR_W-1:0] address_q, address_d;
   logic [DATA_W-1:0] data_q, data_d;

   assign aluReady      = !reset && (fifoCount < CNT_W'(DEPTH));
   assign aluFire       = aluValid && aluReady;
   assign aluEntry.addr = aluAddr;
   assign aluEntry.data = aluData;

   wb_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
      .clk_i       (clk),
      .reset_i     (reset),
      .push_i      (push),
      .pushEntry_i (aluEntry),
      .pop_i       (pop),
      .head_o      (fifoHead),
      .entries_o   (fifoEntries),
      .validMask_o (fifoValid),
      .count_o     (fifoCount)
   );

   // Priority: load, then oldest queued ALU result, then a bypassing ALU result.
   always_comb begin
      push     = 1'b0;
      pop      = 1'b0;
      winValid = 1'b0;
      winner   = '0;
      if (loadValid) begin
         winValid    = 1'b1;
         winner.addr = loadAddr;
         winner.data = loadData;
         push        = aluFire;
      end else if (fifoCount != '0) begin
         winValid = 1'b1;
         winner   = fifoHead;
         pop      = 1'b1;
         push     = aluFire;
      end else if (aluFire) begin
         winValid = 1'b1;
         winner   = aluEntry;
      end
      regWrite_d = winValid && (winner.addr != '0);
      address_d  = winValid ? winner.addr : address_q;
      data_d     = winValid ? winner.data : data_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         regWrite_q <= 1'b0;
         address_q  <= '0;
         data_q     <= '0;
      end else begin
         regWrite_q <= regWrite_d;
         address_q  <= address_d;
         data_q     <= data_d;
      end
   end

   assign regWrite = regWrite_q;
   assign address  = address_q;
   assign data     = data_q;

   always_comb begin
      pendingMask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (fifoValid[i]) begin
            pendingMask[fifoEntries[i].addr] = 1'b1;
         end
      end
      if (regWrite_q) begin
         pendingMask[address_q] = 1'b1;
      end
      pendingMask[0] = 1'b0;
   end

`ifdef WB_COUNT_EN
   logic [31:0] writeCount_q;
   logic [31:0] stallCount_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         writeCount_q <= '0;
         stallCount_q <= '0;
      end else begin
         writeCount_q <= writeCount_q + 32'(regWrite_q);
         stallCount_q <= stallCount_q + 32'(aluValid && !aluReady);
      end
   end

   assign writeCount = writeCount_q;
   assign stallCount = stallCount_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the arbitration rules.
module tb_wb_arbiter;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        loadValid;
   logic [4:0]  loadAddr;
   logic [31:0] loadData;
   logic        aluValid;
   logic        aluReady;
   logic [4:0]  aluAddr;
   logic [31:0] aluData;
   logic        regWrite;
   logic [4:0]  address;
   logic [31:0] data;
   logic [31:0] pendingMask;
`ifdef WB_COUNT_EN
   logic [31:0] writeCount;
   logic [31:0] stallCount;
`endif

   always #5 clk = ~clk;

   wb_arbiter #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .loadValid   (loadValid),
      .loadAddr    (loadAddr),
      .loadData    (loadData),
      .aluValid    (aluValid),
      .aluReady    (aluReady),
      .aluAddr     (aluAddr),
      .aluData     (aluData),
      .regWrite    (regWrite),
      .address     (address),
      .data        (data),
`ifdef WB_COUNT_EN
      .writeCount  (writeCount),
      .stallCount  (stallCount),
`endif
      .pendingMask (pendingMask)
   );

   int total = 0;
   int bad   = 0;

   // Reference model state: queued ALU results in acceptance order, plus the output register.
   logic [36:0] mQ [$];
   logic        mRegWrite;
   logic [4:0]  mAddr;
   logic [31:0] mData;
   logic [31:0] mWrites;
   logic [31:0] mStalls;
   logic        obsReady;
   logic        expReady;

   function automatic logic [31:0] expMask();
      logic [31:0] m;
      m = '0;
      foreach (mQ[i]) m[mQ[i][36:32]] = 1'b1;
      if (mRegWrite) m[mAddr] = 1'b1;
      m[0] = 1'b0;
      return m;
   endfunction

   // Drives one cycle of inputs from a negedge, samples aluReady, advances the model.
   task automatic tick(input logic rst, input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad);
      logic [36:0] w;
      logic        win;
      logic        acc;
      reset     = rst;
      loadValid = lv;
      loadAddr  = la;
      loadData  = ld;
      aluValid  = av;
      aluAddr   = aa;
      aluData   = ad;
      #1;
      obsReady = aluReady;
      expReady = !rst && (mQ.size() < DEPTH);
      acc      = av && expReady;
      @(posedge clk);
      if (rst) begin
         mQ.delete();
         mRegWrite = 1'b0;
         mAddr     = '0;
         mData     = '0;
         mWrites   = '0;
         mStalls   = '0;
      end else begin
         if (mRegWrite) mWrites = mWrites + 1;
         if (av && !expReady) mStalls = mStalls + 1;
         win = 1'b1;
         w   = '0;
         if (lv) begin
            w = {la, ld};
            if (acc) mQ.push_back({aa, ad});
         end else if (mQ.size() > 0) begin
            w = mQ.pop_front();
            if (acc) mQ.push_back({aa, ad});
         end else if (acc) begin
            w = {aa, ad};
         end else begin
            win = 1'b0;
         end
         if (win) begin
            mRegWrite = (w[36:32] != 5'd0);
            mAddr     = w[36:32];
            mData     = w[31:0];
         end else begin
            mRegWrite = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      tick(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         tick(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
         total++;
         if (obsReady !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_aluReady got=%0b want=0", obsReady);
         end
      end
      total++;
      if (regWrite !== 1'b0) begin bad++; $display("[TB] FAIL reset_regWrite got=%0b want=0", regWrite); end
      total++;
      if (address !== 5'd0) begin bad++; $display("[TB] FAIL reset_address got=%0d want=0", address); end
      total++;
      if (data !== 32'd0) begin bad++; $display("[TB] FAIL reset_data got=%h want=0", data); end
      total++;
      if (pendingMask !== 32'd0) begin bad++; $display("[TB] FAIL reset_mask got=%h want=0", pendingMask); end
      idle();
      total++;
      if (obsReady !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_ready got=%0b want=1", obsReady); end
   endtask

   task automatic test_single();
      tick(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h0000_1234);
      total++;
      if (obsReady !== 1'b1) begin bad++; $display("[TB] FAIL single_ready got=%0b want=1", obsReady); end
      total++;
      if (regWrite !== 1'b1 || address !== 5'd5 || data !== 32'h0000_1234) begin
         bad++;
         $display("[TB] FAIL single_write got=%0b/%0d/%h want=1/5/00001234", regWrite, address, data);
      end
      total++;
      if (pendingMask !== 32'h0000_0020) begin bad++; $display("[TB] FAIL single_mask got=%h want=00000020", pendingMask); end
      idle();
      total++;
      if (regWrite !== 1'b0 || address !== 5'd5) begin
         bad++;
         $display("[TB] FAIL single_hold got=%0b/%0d want=0/5", regWrite, address);
      end
   endtask

   task automatic test_contention();
      tick(1'b0, 1'b1, 5'd3, 32'h0000_AAAA, 1'b1, 5'd4, 32'h0000_BBBB);
      total++;
      if (regWrite !== 1'b1 || address !== 5'd3 || data !== 32'h0000_AAAA) begin
         bad++;
         $display("[TB] FAIL contention_load got=%0b/%0d/%h want=1/3/0000aaaa", regWrite, address, data);
      end
      total++;
      if (pendingMask !== 32'h0000_0018) begin bad++; $display("[TB] FAIL contention_mask1 got=%h want=00000018", pendingMask); end
      idle();
      total++;
      if (regWrite !== 1'b1 || address !== 5'd4 || data !== 32'h0000_BBBB) begin
         bad++;
         $display("[TB] FAIL contention_alu got=%0b/%0d/%h want=1/4/0000bbbb", regWrite, address, data);
      end
      total++;
      if (pendingMask !== 32'h0000_0010) begin bad++; $display("[TB] FAIL contention_mask2 got=%h want=00000010", pendingMask); end
      idle();
      total++;
      if (regWrite !== 1'b0 || pendingMask !== 32'd0) begin
         bad++;
         $display("[TB] FAIL contention_drain got=%0b/%h want=0/00000000", regWrite, pendingMask);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] readyWant;
      logic [31:0] stallStart;
      readyWant  = 4'b0011;
      stallStart = mStalls;
      for (int k = 1; k <= 4; k++) begin
         tick(1'b0, 1'b1, 5'(10 + k), 32'(k), 1'b1, 5'(k), 32'h100 + 32'(k));
         total++;
         if (obsReady !== readyWant[k-1]) begin
            bad++;
            $display("[TB] FAIL b2b_ready cycle=%0d got=%0b want=%0b", k, obsReady, readyWant[k-1]);
         end
         total++;
         if (regWrite !== 1'b1 || address !== 5'(10 + k) || data !== 32'(k)) begin
            bad++;
            $display("[TB] FAIL b2b_load cycle=%0d got=%0b/%0d/%h want=1/%0d/%h", k, regWrite, address, data, 10 + k, k);
         end
      end
      total++;
      if (mStalls - stallStart !== 32'd2) begin bad++; $display("[TB] FAIL b2b_model_stalls got=%0d want=2", mStalls - stallStart); end
`ifdef WB_COUNT_EN
      total++;
      if (stallCount !== mStalls) begin bad++; $display("[TB] FAIL b2b_stallCount got=%0d want=%0d", stallCount, mStalls); end
`endif
      idle();
      total++;
      if (obsReady !== 1'b0) begin bad++; $display("[TB] FAIL b2b_full_ready got=%0b want=0", obsReady); end
      total++;
      if (regWrite !== 1'b1 || address !== 5'd1 || data !== 32'h101) begin
         bad++;
         $display("[TB] FAIL b2b_first got=%0b/%0d/%h want=1/1/00000101", regWrite, address, data);
      end
      idle();
      total++;
      if (regWrite !== 1'b1 || address !== 5'd2 || data !== 32'h102) begin
         bad++;
         $display("[TB] FAIL b2b_second got=%0b/%0d/%h want=1/2/00000102", regWrite, address, data);
      end
      idle();
      total++;
      if (regWrite !== 1'b0 || obsReady !== 1'b1) begin
         bad++;
         $display("[TB] FAIL b2b_drained got=%0b/%0b want=0/1", regWrite, obsReady);
      end
   endtask

   task automatic test_r0();
      tick(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
      total++;
      if (obsReady !== 1'b1) begin bad++; $display("[TB] FAIL r0_ready got=%0b want=1", obsReady); end
      total++;
      if (regWrite !== 1'b0 || pendingMask !== 32'd0) begin
         bad++;
         $display("[TB] FAIL r0_write got=%0b/%h want=0/00000000", regWrite, pendingMask);
      end
      idle();
`ifdef WB_COUNT_EN
      total++;
      if (writeCount !== mWrites) begin bad++; $display("[TB] FAIL r0_writeCount got=%0d want=%0d", writeCount, mWrites); end
`endif
      total++;
      if (regWrite !== 1'b0) begin bad++; $display("[TB] FAIL r0_after got=%0b want=0", regWrite); end
   endtask

   task automatic test_reset_flush();
      tick(1'b0, 1'b1, 5'd20, 32'h20, 1'b1, 5'd6, 32'h66);
      tick(1'b0, 1'b1, 5'd21, 32'h21, 1'b1, 5'd7, 32'h77);
      total++;
      if (pendingMask !== 32'h0020_00C0) begin bad++; $display("[TB] FAIL flush_mask_before got=%h want=002000c0", pendingMask); end
      tick(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         idle();
         total++;
         if (regWrite !== 1'b0 || pendingMask !== 32'd0 || obsReady !== 1'b1) begin
            bad++;
            $display("[TB] FAIL flush_after cycle=%0d got=%0b/%h/%0b want=0/00000000/1", i, regWrite, pendingMask, obsReady);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         tick(($urandom_range(0, 59) == 0), ($urandom_range(0, 1) == 1), 5'($urandom), $urandom,
              ($urandom_range(0, 9) < 6), 5'($urandom), $urandom);
         total++;
         if (obsReady !== expReady) begin bad++; $display("[TB] FAIL rand_ready i=%0d got=%0b want=%0b", i, obsReady, expReady); end
         total++;
         if (regWrite !== mRegWrite || address !== mAddr || data !== mData) begin
            bad++;
            $display("[TB] FAIL rand_write i=%0d got=%0b/%0d/%h want=%0b/%0d/%h", i, regWrite, address, data, mRegWrite, mAddr, mData);
         end
         total++;
         if (pendingMask !== expMask()) begin bad++; $display("[TB] FAIL rand_mask i=%0d got=%h want=%h", i, pendingMask, expMask()); end
`ifdef WB_COUNT_EN
         total++;
         if (writeCount !== mWrites || stallCount !== mStalls) begin
            bad++;
            $display("[TB] FAIL rand_counters i=%0d got=%0d/%0d want=%0d/%0d", i, writeCount, stallCount, mWrites, mStalls);
         end
`endif
      end
   endtask

   initial begin
      reset     = 1'b1;
      loadValid = 1'b0;
      loadAddr  = '0;
      loadData  = '0;
      aluValid  = 1'b0;
      aluAddr   = '0;
      aluData   = '0;
      mRegWrite = 1'b0;
      mAddr     = '0;
      mData     = '0;
      mWrites   = '0;
      mStalls   = '0;
      @(negedge clk);
      test_reset();
      test_single();
      test_contention();
      test_back_to_back();
      test_r0();
      test_reset_flush();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
